// File: rtl/dffram_req_adapter.sv
// dffram_req_adapter: byte-addressed valid/ready request channel to DFFRAM
// EN/WE/A/DI strobes, with in-order valid/ready responses.
// A read's data is only on ram_do for the one cycle after the access, so each
// response is either passed straight through or caught in a 2-entry FIFO.
// The FIFO has room for every response that can be outstanding.
// Optional build macro: DFFRAM_ADAPTER_ERR_EN. When it is defined, requests
// whose word address is >= MEM_WORDS are accepted but do not touch the RAM.
// They return rsp_err=1 with rsp_rdata=0.
module dffram_req_adapter #(
  parameter int AW        = 12,
  parameter int MEM_WORDS = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [3:0]    req_be,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_di,
  output logic [AW-1:0] ram_a,
  input  logic [31:0]   ram_do
);

  logic [1:0]    count;
  logic          inflight;
  logic          infl_we;
  logic          infl_err;
  logic          wptr;
  logic          rptr;
  logic [31:0]   fifo_rdata [2];
  logic          fifo_err   [2];
  logic [AW-1:0] a_q;
  logic [31:0]   di_q;

  logic          accept;
  logic          addr_err;
  logic          push;
  logic          pop;
  logic [AW-1:0] word;
  logic [31:0]   infl_rdata;

  assign word = req_addr[AW+1:2];

`ifdef DFFRAM_ADAPTER_ERR_EN
  localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_WORDS);
  assign addr_err = ({1'b0, word} >= MEM_LIM);
`else
  // The word address simply wraps modulo 2^AW; nothing is out of range.
  assign addr_err = 1'b0;
`endif

  // Byte-lane address bits and the size parameter do not feed any logic in
  // every build.
  logic unused_ok;
  assign unused_ok = ^{req_addr[1:0], (MEM_WORDS > 0)};

  // Accept only when every outstanding response, including the one now in
  // flight, still has a guaranteed slot. This uses registered state only, so
  // there is no path from rsp_ready to req_ready.
  assign req_ready = !RST && (({1'b0, count} + {2'b00, inflight}) < 3'd2);
  assign accept    = req_valid && req_ready;

  // RAM strobes are combinational from the accepted request. Between accesses,
  // A and DI hold the last driven value.
  assign ram_en = accept && !addr_err;
  assign ram_we = (ram_en && req_we) ? req_be : 4'b0000;
  assign ram_a  = ram_en ? word : a_q;
  assign ram_di = ram_en ? req_wdata : di_q;

  // Remember the last driven address and data so they can be held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q  <= '0;
      di_q <= '0;
    end else if (ram_en) begin
      a_q  <= word;
      di_q <= req_wdata;
    end
  end

  // One-cycle in-flight marker. The response is formed from ram_do next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= 1'b0;
      infl_we  <= 1'b0;
      infl_err <= 1'b0;
    end else begin
      inflight <= accept;
      infl_we  <= req_we;
      infl_err <= addr_err;
    end
  end

  // Writes and errors return zero data. Reads return whatever the macro drives.
  assign infl_rdata = (infl_we || infl_err) ? 32'h0 : ram_do;

  // The in-flight response bypasses the FIFO only if the FIFO is empty and the
  // consumer takes it this cycle. Otherwise it is queued behind the head.
  assign push = !RST && inflight && !((count == 2'd0) && rsp_ready);
  assign pop  = !RST && (count != 2'd0) && rsp_ready;

  // Two-entry response FIFO. A push and a pop in the same cycle leave the count
  // unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        fifo_rdata[wptr] <= infl_rdata;
        fifo_err[wptr]   <= infl_err;
        wptr             <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The response port shows the FIFO head first, then the fall-through path.
  // It is quiet during reset.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    if (!RST) begin
      if (count != 2'd0) begin
        rsp_valid = 1'b1;
        rsp_rdata = fifo_rdata[rptr];
        rsp_err   = fifo_err[rptr];
      end else if (inflight) begin
        rsp_valid = 1'b1;
        rsp_rdata = infl_rdata;
        rsp_err   = infl_err;
      end
    end
  end

endmodule

// File: tb/tb_dffram_req_adapter.sv
// Bench for dffram_req_adapter. A behavioural DFFRAM drives ram_do.
// The reference model is a shadow memory plus a queue of expected responses.
// Readiness and validity follow from how many responses are outstanding.
module tb_dffram_req_adapter;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [3:0]    req_be = 4'h0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_di;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_do;

  always #5 CLK = ~CLK;

  dffram_req_adapter #(.AW(AW), .MEM_WORDS(1024)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_di(ram_di),
    .ram_a(ram_a), .ram_do(ram_do)
  );

  // Behavioural DFFRAM: the read data appears the cycle after an enabled
  // access, and byte-lane writes are applied.
  bit [31:0] ram [4096];
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= ram[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  // Reference model state.
  typedef struct packed { logic [31:0] rd; logic err; } rsp_t;
  rsp_t      q[$];
  bit [31:0] ref_mem [4096];
  logic [11:0] last_a  = '0;
  logic [31:0] last_di = '0;

  int total = 0;
  int bad   = 0;
  logic acc, fire;
  logic [83:0] o_vec, e_vec;

  // Drive one cycle, capture the observed and expected output vectors, then
  // advance the model past the coming edge.
  task automatic cycle(input logic v, input logic we, input logic [3:0] be,
                       input logic [13:0] a, input logic [31:0] wd,
                       input logic rr, input logic rst);
    logic e_ready, e_rv, e_en, e_err_req, e_err, o_err;
    logic [31:0] e_rd, o_rd;
    logic [3:0] e_we;
    rsp_t r;
    @(negedge CLK);
    RST = rst; req_valid = v; req_we = we; req_be = be;
    req_addr = a; req_wdata = wd; rsp_ready = rr;
    #1;
    e_ready = !rst && (q.size() < 2);
    e_rv    = !rst && (q.size() > 0);
`ifdef DFFRAM_ADAPTER_ERR_EN
    e_err_req = (a[13:2] >= 12'd1024);
`else
    e_err_req = 1'b0;
`endif
    acc  = v && e_ready;
    fire = e_rv && rr;
    e_en = acc && !e_err_req;
    e_we = (e_en && we) ? be : 4'h0;
    if (e_en) begin last_a = a[13:2]; last_di = wd; end
    e_rd  = e_rv ? q[0].rd : 32'h0;
    e_err = e_rv ? q[0].err : 1'b0;
    o_rd  = (e_rv || rst) ? rsp_rdata : 32'h0;
    o_err = (e_rv || rst) ? rsp_err : 1'b0;
    e_vec = {e_ready, e_rv, e_err, e_rd, e_en, e_we, last_a, last_di};
    o_vec = {req_ready, rsp_valid, o_err, o_rd, ram_en, ram_we, ram_a, ram_di};
    if (rst) begin
      q.delete(); last_a = '0; last_di = '0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        r.rd  = (we || e_err_req) ? 32'h0 : ref_mem[a[13:2]];
        r.err = e_err_req;
        q.push_back(r);
        if (e_en && we)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[13:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'($urandom), 4'hF, 14'($urandom), $urandom, 1'b1, 1'b1);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL reset c%0d got=%h want=%h", k, o_vec, e_vec); end
    end
  endtask

  task automatic test_write_read();
    cycle(1'b1, 1'b1, 4'hF, 14'h010, 32'hDEADBEEF, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL wr got=%h want=%h", o_vec, e_vec); end
    total++;
    if (ram_we !== 4'hF || ram_a !== 12'd4) begin bad++; $display("FAIL wr_strobe we=%h a=%0d want we=f a=4", ram_we, ram_a); end
    cycle(1'b1, 1'b0, 4'h0, 14'h010, 32'h0, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL rd got=%h want=%h", o_vec, e_vec); end
    cycle(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rd_data v=%b d=%h e=%b want 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err);
    end
    // partial write over a known word
    cycle(1'b1, 1'b1, 4'hF, 14'h020, 32'h11223344, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL pw0 got=%h want=%h", o_vec, e_vec); end
    cycle(1'b1, 1'b1, 4'b0001, 14'h020, 32'h000000AA, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL pw1 got=%h want=%h", o_vec, e_vec); end
    cycle(1'b1, 1'b0, 4'h0, 14'h020, 32'h0, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL pw_rd got=%h want=%h", o_vec, e_vec); end
    cycle(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h112233AA) begin
      bad++; $display("FAIL partial v=%b d=%h want 1 112233aa", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic sent3 = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      cycle(w < 4, 1'b1, 4'hF, 14'(w << 2), 32'(8'hA0 + w), 1'b1, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL bp_wr%0d got=%h want=%h", w, o_vec, e_vec); end
    end
    for (int w = 1; w <= 2; w++) begin
      cycle(1'b1, 1'b0, 4'h0, 14'(w << 2), 32'h0, 1'b0, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL bp_rd%0d got=%h want=%h", w, o_vec, e_vec); end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(!sent3, 1'b0, 4'h0, 14'h00C, 32'h0, k >= 2, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL bp c%0d got=%h want=%h", k, o_vec, e_vec); end
      if (k == 0) begin
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", req_ready); end
      end
      if (fire) got.push_back(rsp_rdata);
      if (acc) sent3 = 1'b1;
    end
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 32'(8'hA1 + i)) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, got[i], 8'hA1 + i); end
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(k < 8, 1'b0, 4'h0, 14'(($urandom_range(0, 63)) << 2), 32'h0, 1'b1, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL stream c%0d got=%h want=%h", k, o_vec, e_vec); end
      if (first >= 0 && k - first >= 1 && k - first <= 8 && rsp_valid === 1'b1) vcnt++;
      if (acc && first < 0) first = k;
    end
    total++;
    if (vcnt != 8) begin bad++; $display("FAIL stream_valid got=%0d want=8", vcnt); end
  endtask

  task automatic test_random();
    logic [13:0] a;
    for (int k = 0; k < 300; k++) begin
      a = 14'($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 14'h1000;
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom,
            $urandom_range(0, 3) != 0, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL rand c%0d got=%h want=%h", k, o_vec, e_vec); end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL rand_drain c%0d got=%h want=%h", k, o_vec, e_vec); end
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 14'(4 + 4*k), 32'h0, 1'b0, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL rm_rd%0d got=%h want=%h", k, o_vec, e_vec); end
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 14'h00C, 32'h0, 1'b1, 1'b1);
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || ram_en !== 1'b0) begin
        bad++; $display("FAIL rm_rst v=%b r=%b en=%b want 0 0 0", rsp_valid, req_ready, ram_en);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
      total++;
      if (o_vec !== e_vec) begin bad++; $display("FAIL rm_after c%0d got=%h want=%h", k, o_vec, e_vec); end
      if (rsp_valid === 1'b1) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL rm_stale got=%0d want=0", stale); end
  endtask

  task automatic test_range();
    cycle(1'b1, 1'b1, 4'hF, 14'h1000, 32'hCAFEF00D, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL rng_wr got=%h want=%h", o_vec, e_vec); end
`ifdef DFFRAM_ADAPTER_ERR_EN
    total++;
    if (ram_en !== 1'b0) begin bad++; $display("FAIL rng_en got=%b want=0", ram_en); end
`else
    total++;
    if (ram_en !== 1'b1 || ram_a !== 12'h400) begin bad++; $display("FAIL rng_en got=%b a=%h want 1 400", ram_en, ram_a); end
`endif
    cycle(1'b1, 1'b0, 4'h0, 14'h1000, 32'h0, 1'b1, 1'b0);
    total++;
    if (o_vec !== e_vec) begin bad++; $display("FAIL rng_rd got=%h want=%h", o_vec, e_vec); end
    cycle(1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
    total++;
`ifdef DFFRAM_ADAPTER_ERR_EN
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL rng_rsp v=%b e=%b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
`else
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rng_rsp v=%b e=%b d=%h want 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
